modport_dut: RTL and testbench
==============================

MODPORT_DUT -- requirements
Module: modport_dut

Interface
REQ-001 Parameter DATA_W, default 16, data word width.
REQ-002 Parameter ADDR_W, default 8, address width; storage depth is 2**ADDR_W (256 words).
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  asynchronous active-high reset.
REQ-005 Port write  input  1  1 = write cycle, 0 = read cycle.
REQ-006 Port data_in  input  DATA_W  write data; changes only at the rising edge of clk.
REQ-007 Port address  input  ADDR_W  word address for both reads and writes.
REQ-008 Port data_out  output  DATA_W  registered read data.
REQ-009 One clock; reset is asynchronous and active-high (ports clk and rst).

Function
REQ-010 The block SHALL be a 256 x 16 single-port synchronous word memory.
- Write: when write=1 at a rising clk edge, mem[address] <= data_in.
REQ-011 Read: when write=0 at a rising clk edge, data_out <= mem[address].
- Latency is 1 cycle: data_out is valid after the edge that samples address, and is stable through the following falling edge.
REQ-012 During a write cycle, data_out SHALL hold its previous value (no write-through).
- A read of the same address on the next cycle returns the new data.
REQ-013 Back-to-back writes to the same address SHALL leave the last-written value.
- Writes to different addresses SHALL not disturb any other word.
REQ-014 Address wrap: all 256 addresses, 8'h00 through 8'hFF, are valid.
- No out-of-range condition exists; address is never truncated or aliased.
REQ-015 Inputs SHALL be sampled only at the rising clk edge.
- Glitches or skewed transitions between edges SHALL have no effect.
REQ-016 X/Z on write SHALL be treated as a read; memory SHALL not be modified.

Reset
REQ-017 While rst=1, data_out SHALL be 16'h0000, independent of clk.
REQ-018 Asserting rst SHALL clear every memory word to 16'h0000.
REQ-019 A write coincident with rst=1 SHALL be discarded.
REQ-020 After rst deasserts, the first rising clk edge SHALL perform a normal read or write.
REQ-021 Reset mid-operation SHALL abort the pending access.
- data_out reads 0.
- A subsequent read of any address returns 0.

Structure
REQ-022 Package modport_pkg SHALL hold:
- DATA_W, ADDR_W and DEPTH constants.
- typedefs data_t (logic [DATA_W-1:0]) and addr_t (logic [ADDR_W-1:0]).
REQ-023 The storage array and its write/reset logic SHALL be one sub-module, modport_mem.
- The top level holds the read-data register and the write/read decode.
REQ-024 The design SHALL contain no latches and SHALL have a single clock domain.

Verification
REQ-025 Reset check: assert rst mid-simulation -> data_out=16'h0000 immediately; a read of address 8'h10 after release returns 16'h0000.
REQ-026 Write/read: write 16'hA5A5 to 8'h3C, then read 8'h3C -> data_out=16'hA5A5 one cycle after the read edge; data_out unchanged during the write cycle.
REQ-027 Boundary addresses: write 16'h0001 to 8'h00 and 16'hFFFF to 8'hFF, then read both -> 16'h0001 and 16'hFFFF; address 8'h80 still reads 16'h0000.
REQ-028 Overwrite: write 16'h1234 then 16'h5678 to 8'h07 on consecutive cycles, then read -> 16'h5678.
REQ-029 Skewed stimulus: drive write/address 25 ns after the falling edge and sample data_out 15 ns before the falling edge -> all reads match a reference model over 1000 random accesses.
REQ-030 Reset during write: assert rst in the same cycle as a write of 16'hBEEF to 8'h55 -> a later read of 8'h55 returns 16'h0000.

Source files
------------

// File: rtl/modport_pkg.sv
// Shared width constants and word/address types for the modport_dut memory slice.
package modport_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;
endpackage

// File: rtl/modport_mem.sv
// Word storage array with asynchronous clear and synchronous write.
// The read port is combinational; the parent registers it.
module modport_mem #(
  parameter int DATA_W = modport_pkg::DATA_W,
  parameter int ADDR_W = modport_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Reset wipes every word, so a write coincident with rst can never land.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/modport_dut.sv
// Single-port synchronous word memory: decode of write/read and the registered
// read-data output; storage lives in modport_mem.
module modport_dut #(
  parameter int DATA_W = modport_pkg::DATA_W,
  parameter int ADDR_W = modport_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_out
);
  logic              w_we;
  logic [DATA_W-1:0] w_rd_data;
  logic [DATA_W-1:0] r_data_out;

  assign w_we = write;

  modport_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_addr  (address),
    .i_wdata (data_in),
    .o_rdata (w_rd_data)
  );

  // Only a definite 1 holds the output; anything else (including X) reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_out <= '0;
    end else begin
      if (w_we) r_data_out <= r_data_out;
      else      r_data_out <= w_rd_data;
    end
  end

  assign data_out = r_data_out;
endmodule

// File: tb/tb_modport_dut.sv
// Randomized and directed bench for modport_dut against an array-based memory model.
`timescale 1ns/1ps
module tb_modport_dut;
  import modport_pkg::*;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  write = 1'b0;
  data_t data_in = '0;
  addr_t address = '0;
  data_t data_out;

  int n_checks = 0;
  int n_errors = 0;

  data_t m_mem [DEPTH];
  data_t m_out;

  modport_dut dut (
    .clk      (clk),
    .rst      (rst),
    .write    (write),
    .data_in  (data_in),
    .address  (address),
    .data_out (data_out)
  );

  // Rising edges at 50, 150, ...; falling edges at 100, 200, ...
  always #50 clk = ~clk;

  task automatic check(input string tag, input data_t got, input data_t exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_out = '0;
  endtask

  // Glitch inputs shortly after the falling edge, settle 25 ns after it,
  // then sample 15 ns before the next falling edge.
  task automatic access(input bit we, input addr_t a, input data_t d, input string tag);
    @(negedge clk);
    #5;
    write   = 1'($urandom);
    address = addr_t'($urandom);
    data_in = data_t'($urandom);
    #20;
    write   = we;
    address = a;
    data_in = d;
    @(posedge clk);
    #35;
    if (we) begin
      m_mem[a] = d;
      check({tag, "_hold"}, data_out, m_out);
    end else begin
      m_out = m_mem[a];
      check(tag, data_out, m_out);
    end
  endtask

  task automatic release_rst();
    @(negedge clk);
    #25;
    rst   = 1'b0;
    write = 1'b0;
  endtask

  addr_t pick_set [6] = '{8'h00, 8'h01, 8'hFF, 8'h7F, 8'h80, 8'h3C};

  initial begin
    model_clear();
    #10;
    check("por_out", data_out, 16'h0000);
    release_rst();

    access(1'b0, 8'h10, '0, "rd_after_por");
    access(1'b1, 8'h3C, 16'hA5A5, "wr_3c");
    access(1'b0, 8'h3C, '0, "rd_3c");
    access(1'b1, 8'h00, 16'h0001, "wr_00");
    access(1'b1, 8'hFF, 16'hFFFF, "wr_ff");
    access(1'b0, 8'h00, '0, "rd_00");
    access(1'b0, 8'hFF, '0, "rd_ff");
    access(1'b0, 8'h80, '0, "rd_80");
    access(1'b1, 8'h07, 16'h1234, "wr_07a");
    access(1'b1, 8'h07, 16'h5678, "wr_07b");
    access(1'b0, 8'h07, '0, "rd_07");
    access(1'b0, 8'h3C, '0, "rd_3c_again");

    // Asynchronous reset mid-operation, away from any clock edge.
    @(negedge clk);
    #25;
    write   = 1'b0;
    address = 8'hFF;
    rst     = 1'b1;
    #1;
    check("rst_async_out", data_out, 16'h0000);
    model_clear();
    release_rst();
    access(1'b0, 8'h10, '0, "rd_10_after_rst");
    access(1'b0, 8'h3C, '0, "rd_3c_after_rst");
    access(1'b0, 8'hFF, '0, "rd_ff_after_rst");

    // Reset held across the edge of a write.
    access(1'b0, 8'h07, '0, "rd_07_zero");
    @(negedge clk);
    #25;
    write   = 1'b1;
    address = 8'h55;
    data_in = 16'hBEEF;
    #10;
    rst = 1'b1;
    #1;
    check("rst_wr_out", data_out, 16'h0000);
    @(posedge clk);
    #35;
    check("rst_wr_hold", data_out, 16'h0000);
    model_clear();
    release_rst();
    access(1'b0, 8'h55, '0, "rd_55");

    for (int n = 0; n < 1000; n++) begin
      bit    we;
      addr_t a;
      we = 1'($urandom);
      if ($urandom_range(0, 1) == 0) a = pick_set[$urandom_range(0, 5)];
      else                           a = addr_t'($urandom);
      access(we, a, data_t'($urandom), we ? "rnd_wr" : "rnd_rd");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
